// File: rtl/rng_stream_checker_pkg.sv
// Constants, state encoding and reference recurrence shared by the RNG stream
// checker and by any generator model feeding it.
package rng_stream_checker_pkg;

  localparam int WIDTH = 60;
  localparam int R_1   = 59;
  localparam int R_2   = 58;

  localparam int LOCK_COUNT_DEFAULT = 8;
  localparam int LOSS_COUNT_DEFAULT = 4;
  localparam int CNT_W_DEFAULT      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10,
    ST_RSVD   = 2'b11
  } state_e;

  // The all-zero word is a dead state for a pure XOR LFSR, so it escapes to 1.
  function automatic logic [WIDTH-1:0] lfsr_next_word(input logic [WIDTH-1:0] w);
    return {w[WIDTH-2:0], w[R_1] ^ w[R_2] ^ (w == '0)};
  endfunction

endpackage

// File: rtl/rng_stream_checker_lfsr_next.sv
// Combinational one-step LFSR recurrence: shift left, feed back tap XOR,
// with the all-zero word escaping to 1.
module lfsr_next
  import rng_stream_checker_pkg::*;
#(
  parameter int WIDTH = rng_stream_checker_pkg::WIDTH,
  parameter int TAP_A = rng_stream_checker_pkg::R_1,
  parameter int TAP_B = rng_stream_checker_pkg::R_2
) (
  input  logic [WIDTH-1:0] word_i,
  output logic [WIDTH-1:0] next_o
);

  logic zero_escape;

  assign zero_escape = (word_i == '0);
  assign next_o      = {word_i[WIDTH-2:0], word_i[TAP_A] ^ word_i[TAP_B] ^ zero_escape};

endmodule

// File: rtl/rng_stream_checker.sv
// Learns an LFSR generator state from the observed stream, then flywheels its
// own prediction and counts words that break the recurrence while locked.
module rng_stream_checker
  import rng_stream_checker_pkg::*;
#(
  parameter int WIDTH      = rng_stream_checker_pkg::WIDTH,
  parameter int TAP_A      = rng_stream_checker_pkg::R_1,
  parameter int TAP_B      = rng_stream_checker_pkg::R_2,
  parameter int LOCK_COUNT = rng_stream_checker_pkg::LOCK_COUNT_DEFAULT,
  parameter int LOSS_COUNT = rng_stream_checker_pkg::LOSS_COUNT_DEFAULT,
  parameter int CNT_W      = rng_stream_checker_pkg::CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_out
);

  localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int MISS_W  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_COUNT - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pred_q, pred_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic [WIDTH-1:0]   seed_next;
  logic [WIDTH-1:0]   fly_next;
  logic               word_match;
  logic               err_hit;

  // Re-seed path learns from the wire; flywheel path only trusts its own history.
  lfsr_next #(.WIDTH(WIDTH), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_seed_next (
    .word_i (data_in),
    .next_o (seed_next)
  );

  lfsr_next #(.WIDTH(WIDTH), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_fly_next (
    .word_i (pred_q),
    .next_o (fly_next)
  );

  assign word_match = (data_in == pred_q);

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_hit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          pred_d      = seed_next;
          match_cnt_d = '0;
          state_d     = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (valid_in) begin
          pred_d = seed_next;
          if (word_match) begin
            if (match_cnt_q == MATCH_LAST) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
      end

      ST_LOCKED: begin
        if (valid_in) begin
          pred_d = fly_next;
          if (word_match) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_hit     = 1'b1;
            if (miss_cnt_q == MISS_LAST) begin
              // Sustained disagreement: the generator was likely reseeded, relearn it.
              state_d     = ST_SYNC;
              pred_d      = seed_next;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        pred_d      = '0;
        match_cnt_d = '0;
        miss_cnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = '0;
    end else if (err_hit && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pred_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_rng_stream_checker.sv
// Directed-plus-random bench for rng_stream_checker: two instances (default and
// a narrow-counter / long-loss variant) share one stream and a behavioural model.
module tb_rng_stream_checker;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [59:0] data_in;
  logic        clear_err;

  logic        locked_a, pulse_a;
  logic [15:0] cnt_a;
  logic [1:0]  st_a;
  logic        locked_b, pulse_b;
  logic [3:0]  cnt_b;
  logic [1:0]  st_b;

  rng_stream_checker dut_a (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .clear_err (clear_err),
    .locked    (locked_a),
    .err_pulse (pulse_a),
    .err_count (cnt_a),
    .state_out (st_a)
  );

  rng_stream_checker #(.CNT_W(4), .LOSS_COUNT(32)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .clear_err (clear_err),
    .locked    (locked_b),
    .err_pulse (pulse_b),
    .err_count (cnt_b),
    .state_out (st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int n_checks    = 0;
  int n_words     = 0;

  // Behavioural model, one slot per instance: 0 = IDLE, 1 = SYNC, 2 = LOCKED.
  int          lock_n  [2] = '{8, 8};
  int          loss_n  [2] = '{4, 32};
  int          err_max [2] = '{65535, 15};
  int          m_state [2];
  logic [59:0] m_pred  [2];
  int          m_match [2];
  int          m_miss  [2];
  int          m_err   [2];
  bit          m_pulse [2];

  logic [59:0] gen_q;

  function automatic logic [59:0] gen_next(input logic [59:0] w);
    if (w == 60'd0) return 60'd1;
    return {w[58:0], w[59] ^ w[58]};
  endfunction

  function automatic logic [59:0] rand60();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[59:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_pred[k] = '0; m_match[k] = 0;
      m_miss[k] = 0; m_err[k] = 0; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_clock(input int k, input bit v, input logic [59:0] d, input bit clr);
    bit hit;
    hit = 1'b0;
    m_pulse[k] = 1'b0;
    if (v) begin
      if (m_state[k] == 0) begin
        m_pred[k] = gen_next(d); m_match[k] = 0; m_state[k] = 1;
      end else if (m_state[k] == 1) begin
        if (d == m_pred[k]) begin
          m_match[k]++;
          if (m_match[k] == lock_n[k]) begin m_state[k] = 2; m_miss[k] = 0; end
        end else begin
          m_match[k] = 0;
        end
        m_pred[k] = gen_next(d);
      end else begin
        if (d == m_pred[k]) begin
          m_miss[k] = 0;
          m_pred[k] = gen_next(m_pred[k]);
        end else begin
          hit = 1'b1;
          m_pulse[k] = 1'b1;
          m_miss[k]++;
          if (m_miss[k] == loss_n[k]) begin
            m_state[k] = 1; m_pred[k] = gen_next(d); m_match[k] = 0; m_miss[k] = 0;
          end else begin
            m_pred[k] = gen_next(m_pred[k]);
          end
        end
      end
    end
    if (clr) m_err[k] = 0;
    else if (hit && m_err[k] < err_max[k]) m_err[k]++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("a_state",  64'(st_a),     64'(m_state[0]));
    chk("a_locked", 64'(locked_a), 64'(m_state[0] == 2));
    chk("a_pulse",  64'(pulse_a),  64'(m_pulse[0]));
    chk("a_count",  64'(cnt_a),    64'(m_err[0]));
    chk("b_state",  64'(st_b),     64'(m_state[1]));
    chk("b_locked", 64'(locked_b), 64'(m_state[1] == 2));
    chk("b_pulse",  64'(pulse_b),  64'(m_pulse[1]));
    chk("b_count",  64'(cnt_b),    64'(m_err[1]));
  endtask

  task automatic cycle(input bit v, input logic [59:0] d, input bit clr);
    @(negedge clk);
    valid_in = v; data_in = d; clear_err = clr;
    @(posedge clk);
    model_clock(0, v, d, clr);
    model_clock(1, v, d, clr);
    #1;
    check_outputs();
    vectors++;
    if (v) begin
      n_words++;
      $display("word %0d data=%h clr=%0d | a: st=%0d err=%0d pulse=%0d | b: st=%0d err=%0d pulse=%0d",
               n_words, d, clr, st_a, cnt_a, pulse_a, st_b, cnt_b, pulse_b);
    end
  endtask

  task automatic send(input logic [59:0] d);
    int gaps;
    gaps = $urandom_range(0, 3);
    for (int g = 0; g < gaps; g++) cycle(1'b0, rand60(), 1'b0);
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic send_gen();
    send(gen_q);
    gen_q = gen_next(gen_q);
  endtask

  task automatic send_bad();
    logic [59:0] b;
    do b = rand60(); while (b == gen_q);
    send(b);
    gen_q = gen_next(gen_q);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b0; clear_err = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_locked_now", 64'(locked_a), 64'd0);
    chk("rst_count_now",  64'(cnt_a),    64'd0);
    vectors++;
    $display("reset asserted");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; clear_err = 1'b0;
    model_reset();
    #2;
    chk("init_state",  64'(st_a),    64'd0);
    chk("init_locked", 64'(locked_a), 64'd0);
    chk("init_pulse",  64'(pulse_a),  64'd0);
    chk("init_count",  64'(cnt_a),    64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Seed 1, first 12 words: SYNC after word 1, lock after word 9.
    gen_q = 60'd1;
    send_gen();
    chk("t1_sync_after_w1", 64'(st_a), 64'd1);
    for (int i = 0; i < 7; i++) send_gen();
    chk("t1_not_locked_w8", 64'(locked_a), 64'd0);
    send_gen();
    chk("t1_locked_w9", 64'(locked_a), 64'd1);
    for (int i = 0; i < 3; i++) send_gen();
    chk("t1_no_errors", 64'(cnt_a), 64'd0);

    // Single corrupted word 20.
    for (int i = 0; i < 7; i++) send_gen();
    send(60'hABC);
    gen_q = gen_next(gen_q);
    chk("t2_pulse",  64'(pulse_a),  64'd1);
    chk("t2_count",  64'(cnt_a),    64'd1);
    chk("t2_locked", 64'(locked_a), 64'd1);
    send_gen();
    chk("t2_no_second_pulse", 64'(pulse_a), 64'd0);
    chk("t2_count_held",      64'(cnt_a),   64'd1);

    // Four consecutive garbage words drop lock; relock needs 1 reseed + 8 matches.
    cycle(1'b0, '0, 1'b1);
    chk("t3_cleared", 64'(cnt_a), 64'd0);
    for (int i = 0; i < 3; i++) send_bad();
    chk("t3_still_locked", 64'(locked_a), 64'd1);
    send_bad();
    chk("t3_count4", 64'(cnt_a), 64'd4);
    chk("t3_sync",   64'(st_a),  64'd1);
    for (int i = 0; i < 8; i++) send_gen();
    chk("t3_not_yet", 64'(locked_a), 64'd0);
    send_gen();
    chk("t3_relocked", 64'(locked_a), 64'd1);

    // Zero-escape: 0 then 1 then the generator from 1.
    do_reset();
    send(60'd0);
    gen_q = 60'd1;
    send_gen();
    chk("t4_sync",       64'(st_a), 64'd1);
    for (int i = 0; i < 6; i++) send_gen();
    chk("t4_not_locked", 64'(locked_a), 64'd0);
    send_gen();
    chk("t4_locked_a",   64'(locked_a), 64'd1);
    chk("t4_locked_b",   64'(locked_b), 64'd1);

    // Saturation on the 4-bit instance, then clear racing an error.
    for (int i = 0; i < 20; i++) send_bad();
    chk("t5_sat_b",     64'(cnt_b),    64'hF);
    chk("t5_b_locked",  64'(locked_b), 64'd1);
    chk("t5_a_count",   64'(cnt_a),    64'd4);
    cycle(1'b1, ~gen_q, 1'b1);
    gen_q = gen_next(gen_q);
    chk("t5_clear_wins", 64'(cnt_b),   64'd0);
    chk("t5_pulse_b",    64'(pulse_b), 64'd1);
    send_gen();
    chk("t5_after_clear", 64'(cnt_b), 64'd0);

    // Random phase: fresh seed, gaps, sparse corruption, occasional reset.
    do_reset();
    gen_q = rand60();
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) send_bad();
      else if (r == 6 && m_state[0] == 2) do_reset();
      else send_gen();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
